rvx_reset_conditioner: RTL

// Board-level reset conditioner for RVX board tops; sits directly upstream of the SoC reset_n input.

---
 rtl/rvx_reset_conditioner.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/rvx_reset_conditioner.sv
// rvx_reset_conditioner
//   Board-level reset conditioner. It synchronizes and debounces a raw push-button,
//   stretches the resulting reset, and drives a clean, clock-synchronous active-low
//   system reset to the SoC.
//
// Ports
//   clock           in   system clock, all flops on posedge
//   reset_n         in   async active-low reset (POR / PLL lock), clears all state
//   button          in   raw asynchronous push-button level
//   system_reset_n  out  conditioned active-low reset, registered
//   button_stable   out  debounced, polarity-normalized button level (1 = pressed)
//   reset_event     out  one-cycle pulse when a press is accepted from IDLE
//   glitch_count    out  [7:0] saturating count of rejected glitches
//                        (present only when RVX_RESET_COND_GLITCH_COUNT_EN is defined)
//
// Optional feature macro: RVX_RESET_COND_GLITCH_COUNT_EN
module rvx_reset_conditioner #(
  parameter int SYNC_STAGES        = 2,
  parameter int DEBOUNCE_CYCLES    = 100000,
  parameter int STRETCH_CYCLES     = 16,
  parameter int BUTTON_ACTIVE_HIGH = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       button,
  output logic       system_reset_n,
  output logic       button_stable,
  output logic       reset_event
`ifdef RVX_RESET_COND_GLITCH_COUNT_EN
  ,
  output logic [7:0] glitch_count
`endif
);

  generate
    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || STRETCH_CYCLES < 1) begin : g_bad_params
      $error("rvx_reset_conditioner: illegal parameter value");
    end
  endgenerate

  localparam int DW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = (STRETCH_CYCLES < 1) ? 1 : $clog2(STRETCH_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] ST_LAST = SW'(STRETCH_CYCLES - 1);
  // Raw level of a released button; also the synchronizer reset value.
  localparam logic REL_LVL = (BUTTON_ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;

  typedef enum logic [1:0] {ST_STARTUP, ST_IDLE, ST_ASSERT, ST_HOLD} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pressed;
  logic [DW-1:0]          db_cnt_q, db_cnt_d;
  logic                   stable_q, stable_d;
  state_e                 state_q, state_d;
  logic [SW-1:0]          st_cnt_q, st_cnt_d;
  logic                   sys_rst_n_q, sys_rst_n_d;
  logic                   event_q, event_d;

  // Synchronizer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync_q <= {SYNC_STAGES{REL_LVL}};
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], button};
  end

  assign pressed = sync_q[SYNC_STAGES-1] ^ REL_LVL;

  // Debounce: a level change must persist DEBOUNCE_CYCLES cycles to be accepted.
  always_comb begin
    db_cnt_d = db_cnt_q;
    stable_d = stable_q;
    if (pressed != stable_q) begin
      if (db_cnt_q == DB_LAST) begin
        stable_d = ~stable_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DW'(1);
      end
    end else begin
      db_cnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt_q <= '0;
      stable_q <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      stable_q <= stable_d;
    end
  end

  // FSM: state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_STARTUP;
      st_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      st_cnt_q <= st_cnt_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d  = state_q;
    st_cnt_d = st_cnt_q;
    case (state_q)
      ST_STARTUP: begin
        // Once stretched, also wait until no level change is in flight in the
        // debouncer, so a button held across reset_n release lands in ASSERT
        // rather than briefly releasing through IDLE.
        if (st_cnt_q == ST_LAST) begin
          if (pressed == stable_q) begin
            st_cnt_d = '0;
            state_d  = stable_q ? ST_ASSERT : ST_IDLE;
          end
        end else begin
          st_cnt_d = st_cnt_q + SW'(1);
        end
      end
      ST_IDLE: begin
        st_cnt_d = '0;
        if (stable_q) state_d = ST_ASSERT;
      end
      ST_ASSERT: begin
        st_cnt_d = '0;
        if (!stable_q) state_d = ST_HOLD;
      end
      default: begin // ST_HOLD
        if (stable_q) begin
          state_d  = ST_ASSERT;
          st_cnt_d = '0;
        end else if (st_cnt_q == ST_LAST) begin
          state_d  = ST_IDLE;
          st_cnt_d = '0;
        end else begin
          st_cnt_d = st_cnt_q + SW'(1);
        end
      end
    endcase
  end

  // FSM: outputs, computed from the next state and registered so the reset
  // edge is glitch-free and synchronous to clock.
  always_comb begin
    sys_rst_n_d = (state_d == ST_IDLE);
    event_d     = (state_q == ST_IDLE) && (state_d == ST_ASSERT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sys_rst_n_q <= 1'b0;
      event_q     <= 1'b0;
    end else begin
      sys_rst_n_q <= sys_rst_n_d;
      event_q     <= event_d;
    end
  end

  assign system_reset_n = sys_rst_n_q;
  assign button_stable  = stable_q;
  assign reset_event    = event_q;

`ifdef RVX_RESET_COND_GLITCH_COUNT_EN
  // A glitch is a partial debounce run that ends without a toggle.
  logic       glitch;
  logic [7:0] gc_q;

  assign glitch = (pressed == stable_q) && (db_cnt_q != '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                    gc_q <= '0;
    else if (glitch && gc_q != 8'hFF) gc_q <= gc_q + 8'd1;
  end

  assign glitch_count = gc_q;
`endif

endmodule
